// File: rtl/adxl362_pkg.sv
// Shared constants for the ADXL362 SPI front-end and register-file model.
package adxl362_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_FIFO  = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_WDATA = 3'd3,
    S_RDATA = 3'd4,
    S_FIFO  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

endpackage

// File: rtl/adxl362_spi_sync.sv
// Pin synchronizers for SCLK/MOSI/nCS plus edge strobes.
// sample_o/launch_o are mapped from the raw SCLK edges using CPOL/CPHA.
module adxl362_spi_sync #(
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sclk_i,
  input  logic mosi_i,
  input  logic ncs_i,
  output logic sample_o,
  output logic launch_o,
  output logic mosi_o,
  output logic ncs_fall_o,
  output logic ncs_rise_o
);

  localparam logic IDLE_LVL = (CPOL != 0);
  localparam logic TRAIL    = (CPHA != 0);

  logic [SYNC_STAGES-1:0] sclk_q, mosi_q, ncs_q;
  logic                   sclk_prev_q, ncs_prev_q;
  logic                   sclk_s, ncs_s, rise, fall, lead, trail;

  // Synchronizer chains. nCS resets low so a frame already in progress at
  // reset release never looks like a fresh nCS fall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q      <= {SYNC_STAGES{IDLE_LVL}};
      mosi_q      <= '0;
      ncs_q       <= '0;
      sclk_prev_q <= IDLE_LVL;
      ncs_prev_q  <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      ncs_q       <= {ncs_q[SYNC_STAGES-2:0], ncs_i};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
      ncs_prev_q  <= ncs_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev_q;
  assign fall   = ~sclk_s & sclk_prev_q;
  assign lead   = IDLE_LVL ? fall : rise;
  assign trail  = IDLE_LVL ? rise : fall;

  assign sample_o   = TRAIL ? trail : lead;
  assign launch_o   = TRAIL ? lead : trail;
  assign mosi_o     = mosi_q[SYNC_STAGES-1];
  assign ncs_fall_o = ~ncs_s & ncs_prev_q;
  assign ncs_rise_o = ncs_s & ~ncs_prev_q;

endmodule

// File: rtl/adxl362_spi_slave.sv
// ADXL362 SPI slave: command decode, register bursts with auto-increment,
// and FIFO streaming, all in the clk_sys domain.
module adxl362_spi_slave
  import adxl362_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned FIFO_W      = 16,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              nCS,
  output logic              MISO,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        data_write,
  output logic              write,
  output logic              read,
  input  logic [7:0]        data_read,
  input  logic [FIFO_W-1:0] data_fifo_read,
  input  logic              fifo_empty,
  output logic              read_data_fifo,
  output logic              busy,
  output logic              cmd_error
);

  localparam int unsigned NB   = FIFO_W / 8;
  localparam int unsigned FB_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [FB_W-1:0] FB_LAST = FB_W'(NB - 1);

  logic sample, launch, mosi_s, ncs_fall, ncs_rise;

  adxl362_spi_sync #(
    .CPOL(CPOL), .CPHA(CPHA), .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(clk_sys), .rst_ni(rst_n), .sclk_i(SCLK), .mosi_i(MOSI), .ncs_i(nCS),
    .sample_o(sample), .launch_o(launch), .mosi_o(mosi_s),
    .ncs_fall_o(ncs_fall), .ncs_rise_o(ncs_rise)
  );

  state_e            state_q, state_d;
  logic [2:0]        cnt_q;
  logic [6:0]        rx_q;
  logic [7:0]        rx_byte;
  logic [FIFO_W-1:0] tx_q;
  logic [FB_W-1:0]   fb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              write_q, read_q, pop_q, ld_q, inc_q, err_q, wr_mode_q;
  logic              active, byte_done;
  logic              write_d, read_d, fload, fnext, err_set;

  assign active    = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_WDATA) ||
                     (state_q == S_RDATA) || (state_q == S_FIFO);
  assign rx_byte   = {rx_q, mosi_s};
  // nCS rise outranks a coincident 8th sample edge: the byte is dropped.
  assign byte_done = active && sample && !ncs_rise && (cnt_q == 3'd7);

  // FSM state register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ncs_fall) state_d = S_CMD;
      S_ERR:  if (ncs_rise) state_d = S_IDLE;
      default: begin
        if (ncs_rise) state_d = S_IDLE;
        else if (byte_done) begin
          case (state_q)
            S_CMD: begin
              if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) state_d = S_ADDR;
              else if (rx_byte == CMD_FIFO)                    state_d = S_FIFO;
              else                                             state_d = S_ERR;
            end
            S_ADDR:  state_d = wr_mode_q ? S_WDATA : S_RDATA;
            default: state_d = state_q;
          endcase
        end
      end
    endcase
  end

  // FSM strobe decode at byte boundaries
  always_comb begin
    write_d = byte_done && (state_q == S_WDATA);
    read_d  = byte_done && (((state_q == S_ADDR) && !wr_mode_q) || (state_q == S_RDATA));
    fload   = byte_done && (((state_q == S_CMD) && (rx_byte == CMD_FIFO)) ||
                            ((state_q == S_FIFO) && (fb_q == FB_LAST)));
    fnext   = byte_done && (state_q == S_FIFO) && (fb_q != FB_LAST);
    err_set = byte_done && (state_q == S_CMD) && (rx_byte != CMD_WRITE) &&
              (rx_byte != CMD_READ) && (rx_byte != CMD_FIFO);
  end

  // Datapath: bit counter, RX/TX shifters, address counter, output strobes.
  // TX bit 7 is always the bit on MISO; a launch edge shifts only the low
  // byte, and the first launch of each byte (cnt_q == 0) is skipped because
  // that bit was already placed at the byte boundary.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      fb_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      pop_q     <= 1'b0;
      ld_q      <= 1'b0;
      inc_q     <= 1'b0;
      err_q     <= 1'b0;
      wr_mode_q <= 1'b0;
    end else begin
      write_q <= write_d;
      read_q  <= read_d;
      ld_q    <= read_q;
      inc_q   <= write_q;
      pop_q   <= fload && !fifo_empty;

      if (state_q == S_IDLE && ncs_fall) begin
        cnt_q <= '0;
        rx_q  <= '0;
        tx_q  <= '0;
        fb_q  <= '0;
        err_q <= 1'b0;
      end else if (state_q != S_IDLE && ncs_rise) begin
        cnt_q <= '0;
        rx_q  <= '0;
        tx_q  <= '0;
        fb_q  <= '0;
      end else begin
        if (active && sample) begin
          rx_q  <= rx_byte[6:0];
          cnt_q <= cnt_q + 3'd1;
        end
        if (fload) begin
          tx_q <= fifo_empty ? '0 : data_fifo_read;
          fb_q <= '0;
        end else if (fnext) begin
          tx_q <= tx_q >> 8;
          fb_q <= fb_q + FB_W'(1);
        end else if (ld_q && state_q == S_RDATA) begin
          tx_q   <= FIFO_W'(data_read);
          addr_q <= addr_q + ADDR_W'(1);
        end else if (launch && (state_q == S_RDATA || state_q == S_FIFO) && cnt_q != 3'd0) begin
          tx_q[7:0] <= {tx_q[6:0], 1'b0};
        end
        if (byte_done && state_q == S_CMD) wr_mode_q <= (rx_byte == CMD_WRITE);
        if (byte_done && state_q == S_ADDR) addr_q <= rx_byte[ADDR_W-1:0];
        if (inc_q && state_q == S_WDATA) addr_q <= addr_q + ADDR_W'(1);
        if (write_d) wdata_q <= rx_byte;
        if (err_set) err_q <= 1'b1;
      end
    end
  end

  assign MISO           = tx_q[7];
  assign miso_oe        = (state_q == S_RDATA) || (state_q == S_FIFO);
  assign address        = addr_q;
  assign data_write     = wdata_q;
  assign write          = write_q;
  assign read           = read_q;
  assign read_data_fifo = pop_q;
  assign busy           = (state_q != S_IDLE);
  assign cmd_error      = err_q;

endmodule

// File: tb/tb_adxl362_spi_slave.sv
// Bench for adxl362_spi_slave: one DUT per SPI mode, a register-file and
// FIFO model, and scoreboard queues for writes, reads and MISO bytes.
`timescale 1ns/1ps
module tb_adxl362_spi_slave;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mosi = 1'b0;
  logic [3:0] sclk = 4'b1100;
  logic [3:0] ncs = 4'hF;
  logic [3:0] miso, oe, wr, rd, pop, busy, err;
  logic [5:0] addr [4];
  logic [7:0] wdat [4];
  logic [7:0] drd [4];
  logic [7:0] mem [64];
  logic [15:0] fifo_mem [8];
  logic [2:0] rd_ptr, wr_ptr;
  logic [15:0] fhead;
  logic        fempty;

  logic [7:0]  tx_buf [16];
  logic [7:0]  rx_buf [16];
  logic [13:0] obs_wr [$];
  logic [13:0] exp_wr [$];
  logic [5:0]  obs_rd [$];
  logic [5:0]  exp_rd [$];
  logic [7:0]  exp_rx [$];
  int          pop_cnt = 0, oe_cnt = 0;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    adxl362_spi_slave #(
      .ADDR_W(6), .FIFO_W(16), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)
    ) u_dut (
      .clk_sys(clk), .rst_n(rst_n), .SCLK(sclk[g]), .MOSI(mosi), .nCS(ncs[g]),
      .MISO(miso[g]), .miso_oe(oe[g]), .address(addr[g]), .data_write(wdat[g]),
      .write(wr[g]), .read(rd[g]), .data_read(drd[g]), .data_fifo_read(fhead),
      .fifo_empty(fempty), .read_data_fifo(pop[g]), .busy(busy[g]), .cmd_error(err[g])
    );
  end

  assign fempty = (rd_ptr == wr_ptr);
  assign fhead  = fifo_mem[rd_ptr];

  // register file read port and FIFO pop
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      for (int m = 0; m < 4; m++) drd[m] <= '0;
    end else begin
      for (int m = 0; m < 4; m++) if (rd[m]) drd[m] <= mem[addr[m]];
      if (|pop) rd_ptr <= rd_ptr + 3'd1;
    end
  end

  // observers, sampled away from the active edge
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (wr[m]) obs_wr.push_back({addr[m], wdat[m]});
      if (rd[m]) obs_rd.push_back(addr[m]);
    end
    if (|pop) pop_cnt <= pop_cnt + 1;
    if (|oe)  oe_cnt  <= oe_cnt + 1;
  end

  task automatic xfer(input int m, input int nbits, input bit keep_cs);
    logic idle, cpha, bitv;
    idle = ((m >> 1) & 1) != 0;
    cpha = (m & 1) != 0;
    for (int i = 0; i < 16; i++) rx_buf[i] = '0;
    ncs[m] = 1'b0;
    #(HALF);
    for (int b = 0; b < nbits; b++) begin
      bitv = tx_buf[b / 8][7 - (b % 8)];
      if (!cpha) begin
        mosi = bitv;
        #(HALF);
        sclk[m] = ~idle;
        rx_buf[b / 8] = {rx_buf[b / 8][6:0], miso[m]};
        #(HALF);
        sclk[m] = idle;
      end else begin
        sclk[m] = ~idle;
        mosi = bitv;
        #(HALF);
        sclk[m] = idle;
        rx_buf[b / 8] = {rx_buf[b / 8][6:0], miso[m]};
        #(HALF);
      end
    end
    #(HALF);
    if (!keep_cs) begin
      ncs[m] = 1'b1;
      #(2 * HALF);
    end
  endtask

  task automatic test_reset();
    #1;
    for (int m = 0; m < 4; m++) begin
      n_checks++;
      if ({addr[m], wdat[m], wr[m], rd[m], pop[m], busy[m], err[m], miso[m], oe[m]} !== 21'd0) begin
        n_fail++;
        $display("FAIL reset_outputs m%0d: got addr=%h wd=%h strobes=%b%b%b busy=%b err=%b miso=%b oe=%b want all 0",
                 m, addr[m], wdat[m], wr[m], rd[m], pop[m], busy[m], err[m], miso[m], oe[m]);
      end
    end
  endtask

  task automatic test_write();
    logic [13:0] e, o;
    obs_wr.delete(); exp_wr.delete();
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h1F; tx_buf[2] = 8'h5A; tx_buf[3] = 8'hA5;
    exp_wr.push_back({6'h1F, 8'h5A});
    exp_wr.push_back({6'h20, 8'hA5});
    xfer(0, 32, 0);
    n_checks++;
    if (obs_wr.size() !== exp_wr.size()) begin
      n_fail++;
      $display("FAIL write_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL write_entry: got addr=%h data=%h want addr=%h data=%h", o[13:8], o[7:0], e[13:8], e[7:0]);
      end
    end
    n_checks++;
    if (err[0] !== 1'b0) begin n_fail++; $display("FAIL write_cmd_error: got %b want 0", err[0]); end
    n_checks++;
    if (addr[0] !== 6'h21) begin n_fail++; $display("FAIL write_addr_final: got %h want 21", addr[0]); end
  endtask

  task automatic test_read(input int m);
    logic [7:0] eb;
    logic [5:0] ea, oa;
    obs_rd.delete(); exp_rd.delete(); exp_rx.delete(); obs_wr.delete();
    mem[6'h3F] = 8'hC3; mem[6'h00] = 8'h3C; mem[6'h01] = 8'h5E;
    tx_buf[0] = 8'h0B; tx_buf[1] = 8'h3F; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
    exp_rx.push_back(8'hC3); exp_rx.push_back(8'h3C);
    exp_rd.push_back(6'h3F); exp_rd.push_back(6'h00); exp_rd.push_back(6'h01);
    xfer(m, 32, 0);
    for (int i = 2; i < 4; i++) begin
      eb = exp_rx.pop_front();
      n_checks++;
      if (rx_buf[i] !== eb) begin
        n_fail++;
        $display("FAIL read_miso m%0d byte%0d: got %h want %h", m, i, rx_buf[i], eb);
      end
    end
    n_checks++;
    if (obs_rd.size() !== exp_rd.size()) begin
      n_fail++;
      $display("FAIL read_count m%0d: got %0d want %0d", m, obs_rd.size(), exp_rd.size());
    end
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      ea = exp_rd.pop_front(); oa = obs_rd.pop_front();
      n_checks++;
      if (oa !== ea) begin n_fail++; $display("FAIL read_addr m%0d: got %h want %h", m, oa, ea); end
    end
    n_checks++;
    if (obs_wr.size() !== 0) begin n_fail++; $display("FAIL read_no_write m%0d: got %0d writes want 0", m, obs_wr.size()); end
  endtask

  task automatic test_fifo();
    int p0, o0;
    logic [7:0] eb;
    exp_rx.delete();
    fifo_mem[rd_ptr] = 16'h1234;
    fifo_mem[rd_ptr + 3'd1] = 16'hABCD;
    fifo_mem[rd_ptr + 3'd2] = 16'h0000;
    wr_ptr = rd_ptr + 3'd2;
    p0 = pop_cnt; o0 = oe_cnt;
    tx_buf[0] = 8'h0D;
    for (int i = 1; i < 6; i++) tx_buf[i] = 8'h00;
    exp_rx.push_back(8'h34); exp_rx.push_back(8'h12); exp_rx.push_back(8'hCD);
    exp_rx.push_back(8'hAB); exp_rx.push_back(8'h00);
    xfer(0, 48, 0);
    for (int i = 1; i < 6; i++) begin
      eb = exp_rx.pop_front();
      n_checks++;
      if (rx_buf[i] !== eb) begin n_fail++; $display("FAIL fifo_miso byte%0d: got %h want %h", i, rx_buf[i], eb); end
    end
    n_checks++;
    if (pop_cnt - p0 !== 2) begin n_fail++; $display("FAIL fifo_pops: got %0d want 2", pop_cnt - p0); end
    n_checks++;
    if (fempty !== 1'b1) begin n_fail++; $display("FAIL fifo_empty_after: got %b want 1", fempty); end
    n_checks++;
    if (oe_cnt - o0 <= 0) begin n_fail++; $display("FAIL fifo_miso_oe: got %0d enabled cycles want >0", oe_cnt - o0); end
  endtask

  task automatic test_abort();
    obs_wr.delete();
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h05; tx_buf[2] = 8'hFF;
    xfer(0, 21, 1);
    ncs[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy[0]); end
    #(2 * HALF);
    n_checks++;
    if (obs_wr.size() !== 0) begin n_fail++; $display("FAIL abort_no_write: got %0d writes want 0", obs_wr.size()); end
    n_checks++;
    if (addr[0] !== 6'h05) begin n_fail++; $display("FAIL abort_addr_hold: got %h want 05", addr[0]); end
  endtask

  task automatic test_error();
    int p0, o0;
    obs_wr.delete(); obs_rd.delete();
    p0 = pop_cnt; o0 = oe_cnt;
    tx_buf[0] = 8'h7E; tx_buf[1] = 8'h0B; tx_buf[2] = 8'h3F; tx_buf[3] = 8'h0D;
    xfer(0, 32, 1);
    n_checks++;
    if (err[0] !== 1'b1) begin n_fail++; $display("FAIL error_flag: got %b want 1", err[0]); end
    n_checks++;
    if (oe_cnt - o0 !== 0) begin n_fail++; $display("FAIL error_miso_oe: got %0d enabled cycles want 0", oe_cnt - o0); end
    n_checks++;
    if (obs_wr.size() + obs_rd.size() + (pop_cnt - p0) !== 0) begin
      n_fail++;
      $display("FAIL error_strobes: got wr=%0d rd=%0d pop=%0d want 0", obs_wr.size(), obs_rd.size(), pop_cnt - p0);
    end
    ncs[0] = 1'b1;
    #(2 * HALF);
    n_checks++;
    if (err[0] !== 1'b1) begin n_fail++; $display("FAIL error_sticky: got %b want 1", err[0]); end
    ncs[0] = 1'b0;
    #(HALF);
    n_checks++;
    if (err[0] !== 1'b0) begin n_fail++; $display("FAIL error_cleared: got %b want 0", err[0]); end
    ncs[0] = 1'b1;
    #(2 * HALF);
  endtask

  task automatic test_reset_mid();
    logic [13:0] e, o;
    mem[6'h3F] = 8'hC3;
    tx_buf[0] = 8'h0B; tx_buf[1] = 8'h3F; tx_buf[2] = 8'h00;
    xfer(1, 20, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({addr[1], wdat[1], wr[1], rd[1], pop[1], busy[1], err[1], miso[1], oe[1]} !== 21'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got addr=%h busy=%b oe=%b miso=%b want all 0", addr[1], busy[1], oe[1], miso[1]);
    end
    #50 rst_n = 1'b1;
    obs_wr.delete(); obs_rd.delete();
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h44; tx_buf[2] = 8'h99;
    xfer(1, 24, 1);
    n_checks++;
    if (busy[1] !== 1'b0 || obs_wr.size() !== 0) begin
      n_fail++;
      $display("FAIL midreset_ignored: got busy=%b writes=%0d want busy=0 writes=0", busy[1], obs_wr.size());
    end
    ncs[1] = 1'b1;
    #(2 * HALF);
    exp_wr.delete();
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h10; tx_buf[2] = 8'h77;
    exp_wr.push_back({6'h10, 8'h77});
    xfer(1, 24, 0);
    n_checks++;
    if (obs_wr.size() !== exp_wr.size()) begin
      n_fail++;
      $display("FAIL midreset_write_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midreset_write_entry: got addr=%h data=%h want addr=%h data=%h", o[13:8], o[7:0], e[13:8], e[7:0]);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wr_ptr = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) fifo_mem[i] = 16'h0000;
    #20;
    test_reset();
    #30 rst_n = 1'b1;
    #(2 * HALF);
    test_write();
    for (int m = 1; m < 4; m++) test_read(m);
    test_fifo();
    test_abort();
    test_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
